// File: rtl/neuron_input_arbiter.sv
// Round-robin arbiter sharing one neuron input channel between N 4-phase
// requesters, with periodic leak events injected into the same channel.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant outstanding; arbitrate pending leak, then requesters
// ISSUE | nrn_req high, waiting for synchronized neuron ack
// RTZ   | return-to-zero: waiting for ack low and granted req low
module neuron_input_arbiter #(
   parameter int N           = 4,
   parameter int LEAK_PERIOD = 64,
   parameter int IDW         = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   src_req,
   output logic [N-1:0]   src_ack,
   output logic           nrn_req,
   input  logic           nrn_ack,
   output logic [IDW-1:0] grant_id,
   output logic           grant_vld,
   input  logic           leak_en,
   output logic           leak_ovf
);

   localparam int PW          = $clog2(N);
   localparam int LCW         = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
   localparam int LEAK_LAST_I = (LEAK_PERIOD > 1) ? LEAK_PERIOD - 1 : 0;
   localparam logic [LCW-1:0] LEAK_LAST = LCW'(LEAK_LAST_I);
   localparam logic [IDW-1:0] LEAK_ID   = IDW'(N);
   localparam bit             LEAK_ON   = (LEAK_PERIOD > 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RTZ   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [LCW-1:0]   leak_cnt, leak_cnt_nxt;
   logic             leak_pend, leak_pend_nxt;
   logic             leak_wrap, leak_clr;
   logic             ack_meta, ack_s;
   logic [N-1:0]     src_ack_nxt;
   logic             nrn_req_nxt;
   logic [IDW-1:0]   grant_id_nxt;
   logic             grant_vld_nxt;
   logic             leak_ovf_nxt;
   logic [N-1:0]     req_rot;
   logic             req_found;
   logic [PW:0]      pick_sum;
   logic [PW-1:0]    pick;
   logic             gnt_req;

   // Two-flop synchronizer for the self-timed neuron acknowledge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= nrn_ack;
         ack_s    <= ack_meta;
      end
   end

   // Leak period counter; a wrap while a leak is still pending is dropped.
   always_comb begin
      leak_wrap     = LEAK_ON && leak_en && (leak_cnt == LEAK_LAST);
      leak_cnt_nxt  = leak_cnt;
      if (LEAK_ON && leak_en)
         leak_cnt_nxt = leak_wrap ? '0 : leak_cnt + 1'b1;
      leak_pend_nxt = leak_wrap ? 1'b1 : (leak_clr ? 1'b0 : leak_pend);
      leak_ovf_nxt  = leak_wrap && leak_pend && !leak_clr;
   end

   // Rotating-priority search: first set request at or above rr_ptr, wrapping.
   always_comb begin
      req_rot   = N'({src_req, src_req} >> rr_ptr);
      req_found = 1'b0;
      pick_sum  = '0;
      for (int i = 0; i < N; i++) begin
         if (!req_found && req_rot[i]) begin
            req_found = 1'b1;
            pick_sum  = {1'b0, rr_ptr} + (PW + 1)'(i);
         end
      end
      if (pick_sum >= (PW + 1)'(N))
         pick = PW'(pick_sum - (PW + 1)'(N));
      else
         pick = PW'(pick_sum);
   end

   // Request level of the currently granted source (zero for a leak grant).
   always_comb begin
      gnt_req = 1'b0;
      for (int i = 0; i < N; i++)
         if (grant_id == IDW'(i))
            gnt_req = src_req[i];
   end

   // Next-state and registered-output logic of the handshake FSM.
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      src_ack_nxt   = src_ack;
      nrn_req_nxt   = nrn_req;
      grant_id_nxt  = grant_id;
      grant_vld_nxt = grant_vld;
      leak_clr      = 1'b0;
      case (state)
         S_IDLE: begin
            if (leak_pend) begin
               leak_clr      = 1'b1;
               grant_id_nxt  = LEAK_ID;
               nrn_req_nxt   = 1'b1;
               grant_vld_nxt = 1'b1;
               state_nxt     = S_ISSUE;
            end else if (req_found) begin
               grant_id_nxt  = IDW'(pick);
               nrn_req_nxt   = 1'b1;
               grant_vld_nxt = 1'b1;
               state_nxt     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ack_s) begin
               nrn_req_nxt = 1'b0;
               for (int i = 0; i < N; i++)
                  if (grant_id == IDW'(i))
                     src_ack_nxt[i] = 1'b1;
               state_nxt = S_RTZ;
            end
         end
         S_RTZ: begin
            if (!ack_s && !gnt_req) begin
               src_ack_nxt   = '0;
               grant_vld_nxt = 1'b0;
               if (grant_id != LEAK_ID) begin
                  if (grant_id[PW-1:0] == PW'(N - 1))
                     rr_ptr_nxt = '0;
                  else
                     rr_ptr_nxt = grant_id[PW-1:0] + 1'b1;
               end
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, pointer, leak and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         leak_cnt  <= '0;
         leak_pend <= 1'b0;
         src_ack   <= '0;
         nrn_req   <= 1'b0;
         grant_id  <= '0;
         grant_vld <= 1'b0;
         leak_ovf  <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         leak_cnt  <= leak_cnt_nxt;
         leak_pend <= leak_pend_nxt;
         src_ack   <= src_ack_nxt;
         nrn_req   <= nrn_req_nxt;
         grant_id  <= grant_id_nxt;
         grant_vld <= grant_vld_nxt;
         leak_ovf  <= leak_ovf_nxt;
      end
   end

endmodule

// File: tb/tb_neuron_input_arbiter.sv
// Directed bench for neuron_input_arbiter (N=4, LEAK_PERIOD=8).
module tb_neuron_input_arbiter;

   localparam int N  = 4;
   localparam int LP = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] src_req;
   logic [N-1:0] src_ack;
   logic         nrn_req;
   logic         nrn_ack;
   logic [2:0]   grant_id;
   logic         grant_vld;
   logic         leak_en;
   logic         leak_ovf;

   int tests = 0;
   int fails = 0;

   neuron_input_arbiter #(.N(N), .LEAK_PERIOD(LP)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_req   (src_req),
      .src_ack   (src_ack),
      .nrn_req   (nrn_req),
      .nrn_ack   (nrn_ack),
      .grant_id  (grant_id),
      .grant_vld (grant_vld),
      .leak_en   (leak_en),
      .leak_ovf  (leak_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      src_req = '0;
      nrn_ack = 1'b0;
      leak_en = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // One complete transaction with a neuron that acks 3 cycles after the request.
   task automatic do_grant(input int exp_id, input bit keep);
      int n;
      n = 0;
      while (!nrn_req && n < 20) begin tick(); n++; end
      chk("gnt_req", nrn_req, 1);
      chk("gnt_id", grant_id, exp_id);
      chk("gnt_vld", grant_vld, 1);
      repeat (3) tick();
      nrn_ack = 1'b1;
      n = 0;
      while (nrn_req && n < 10) begin tick(); n++; end
      chk("req_fall", nrn_req, 0);
      chk("ack_vec", src_ack, (exp_id < N) ? (32'd1 << exp_id) : 32'd0);
      if (exp_id < N) src_req[exp_id] = 1'b0;
      nrn_ack = 1'b0;
      n = 0;
      while (grant_vld && n < 10) begin tick(); n++; end
      chk("rtz_vld", grant_vld, 0);
      chk("rtz_ack", src_ack, 0);
      if (keep && exp_id < N) src_req[exp_id] = 1'b1;
   endtask

   initial begin
      int cnt;
      rst = 1'b0; src_req = '0; nrn_ack = 1'b0; leak_en = 1'b0;

      // reset state
      do_reset();
      chk("rst_ack", src_ack, 0);
      chk("rst_req", nrn_req, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_vld", grant_vld, 0);
      chk("rst_ovf", leak_ovf, 0);

      // single requester, exact cycle timing
      src_req = 4'b0100;
      tick();
      chk("s_req_c1", nrn_req, 1);
      chk("s_gid_c1", grant_id, 2);
      chk("s_vld_c1", grant_vld, 1);
      repeat (4) tick();
      nrn_ack = 1'b1;
      repeat (2) tick();
      chk("s_req_c7", nrn_req, 1);
      chk("s_ack_c7", src_ack, 0);
      tick();
      chk("s_req_c8", nrn_req, 0);
      chk("s_ack_c8", src_ack, 4'b0100);
      src_req = '0;
      nrn_ack = 1'b0;
      repeat (2) tick();
      chk("s_ack_c10", src_ack, 4'b0100);
      chk("s_vld_c10", grant_vld, 1);
      tick();
      chk("s_ack_c11", src_ack, 0);
      chk("s_vld_c11", grant_vld, 0);
      src_req = 4'b1100;
      tick();
      chk("s_rr3", grant_id, 3);
      do_grant(3, 0);

      // round-robin fairness with all sources requesting
      do_reset();
      src_req = 4'b1111;
      do_grant(0, 1);
      do_grant(1, 1);
      do_grant(2, 1);
      do_grant(3, 1);
      do_grant(0, 1);
      src_req = '0;

      // src_req falling during ISSUE does not abort the grant
      do_reset();
      src_req = 4'b0001;
      tick();
      src_req = 4'b0010;
      do_grant(0, 0);
      do_grant(1, 0);

      // leak beats requesters; leak grant leaves rr_ptr alone
      do_reset();
      leak_en = 1'b1;
      repeat (8) tick();
      chk("lp_req_c8", nrn_req, 0);
      src_req = 4'b0011;
      tick();
      chk("lp_req_c9", nrn_req, 1);
      chk("lp_gid_c9", grant_id, 4);
      leak_en = 1'b0;
      do_grant(4, 0);
      do_grant(0, 0);
      do_grant(1, 0);

      // leak overflow while the neuron withholds its ack
      do_reset();
      leak_en = 1'b1;
      src_req = 4'b0001;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c == 1) chk("ov_gid", grant_id, 0);
         chk("ov_pulse", leak_ovf, (c == 16 || c == 24) ? 1 : 0);
      end
      leak_en = 1'b0;
      do_grant(0, 0);
      do_grant(4, 0);
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (nrn_req) cnt++;
      end
      chk("ov_extra", cnt, 0);

      // leak_en=0 freezes the counter
      do_reset();
      leak_en = 1'b1;
      repeat (3) tick();
      leak_en = 1'b0;
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (nrn_req) cnt++;
      end
      chk("fr_none", cnt, 0);
      leak_en = 1'b1;
      repeat (5) tick();
      chk("fr_req_r5", nrn_req, 0);
      tick();
      chk("fr_req_r6", nrn_req, 1);
      chk("fr_gid_r6", grant_id, 4);
      leak_en = 1'b0;
      do_grant(4, 0);

      // reset in the middle of a handshake
      do_reset();
      src_req = 4'b1000;
      tick();
      chk("rm_gid", grant_id, 3);
      nrn_ack = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("rm_ack", src_ack, 0);
      chk("rm_req", nrn_req, 0);
      chk("rm_vld", grant_vld, 0);
      rst = 1'b0;
      nrn_ack = 1'b0;
      tick();
      chk("rm_regnt", grant_id, 3);
      chk("rm_regreq", nrn_req, 1);
      tick();
      chk("rm_hold", nrn_req, 1);
      do_grant(3, 0);

      // reset returns rr_ptr to 0
      do_reset();
      src_req = 4'b0010;
      do_grant(1, 0);
      do_reset();
      src_req = 4'b1010;
      tick();
      chk("rr_rst", grant_id, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/neuron_input_arbiter.md
Name: neuron_input_arbiter

Overview:
- Synchronous round-robin arbiter that shares one spiking neuron's input channel between N presynaptic requesters.
- Also injects periodic leak events into the same channel.
- Each upstream channel is a 4-phase req/ack pair. The downstream channel drives the neuron control's req_in/ack_in pair.
- The neuron side is self-timed, so its ack is 2-flop synchronized inside the block.
- grant_id tells the datapath mux which weight to apply. Code N means leak.

Parameters:
- N, 4, number of presynaptic requesters (2..16).
- LEAK_PERIOD, 64, clock cycles between leak events; 0 disables leak generation.
- IDW, $clog2(N+1), width of grant_id (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- src_req  input  N  per-requester 4-phase request; synchronous to clk.
- src_ack  output  N  per-requester 4-phase acknowledge.
- nrn_req  output  1  request to neuron input channel.
- nrn_ack  input  1  acknowledge from neuron; asynchronous to clk.
- grant_id  output  IDW  index of the channel being served; N = leak event.
- grant_vld  output  1  high while grant_id is valid (ISSUE and RTZ states).
- leak_en  input  1  enables the leak counter.
- leak_ovf  output  1  one-cycle pulse when a leak event is dropped.

Behaviour:
- Reset values (one edge with rst=1): src_ack=0, nrn_req=0, grant_id=0, grant_vld=0, leak_ovf=0. Also state=IDLE, rr_ptr=0, leak_cnt=0, leak_pend=0, sync flops=0. Reset mid-handshake aborts the transaction immediately; no completion is owed.
- All outputs are registered.
- ack_s is nrn_ack after 2 flops, so an nrn_ack edge is visible 2 cycles later.
- State IDLE:
  - If leak_pend=1: grant_id=N, clear leak_pend, go to ISSUE.
  - Otherwise, if any src_req=1: grant the first set bit searching from rr_ptr upward with wrap, and go to ISSUE.
  - On the transition, nrn_req=1 and grant_vld=1 on the next edge.
  - Latency from src_req rise to nrn_req rise is 1 cycle.
- State ISSUE:
  - Hold nrn_req=1 until ack_s=1.
  - On that edge set nrn_req=0 and, if grant_id<N, set src_ack[grant_id]=1. Go to RTZ.
  - Leak grants raise no src_ack.
- State RTZ:
  - Wait until ack_s=0 and, for a src grant, src_req[grant_id]=0.
  - On that edge set src_ack=0 and grant_vld=0. For a src grant, set rr_ptr=(grant_id+1) mod N; leak grants leave rr_ptr unchanged. Go to IDLE.
- Minimum of one IDLE cycle between grants. Back-to-back transactions never overlap.
- Priority: a pending leak beats all sources. Among sources, rotating priority is fair; any continuously requesting source is served within N grants (plus interleaved leaks).
- Leak counter:
  - When leak_en=1 and LEAK_PERIOD>0, leak_cnt increments each cycle and wraps from LEAK_PERIOD-1 to 0.
  - On wrap, leak_pend is set. If leak_pend is already 1, the event is dropped and leak_ovf pulses high for 1 cycle.
  - leak_en=0 freezes leak_cnt and does not clear leak_pend.
- Simultaneous events:
  - Leak wrap in the same cycle as IDLE arbitration: arbitration uses the old leak_pend, so the new leak is served on the next IDLE.
  - A wrap on the same edge that IDLE clears leak_pend sets leak_pend and is not an overflow.
- Protocol violations:
  - src_req falling in ISSUE is ignored; the grant completes.
  - Requests of non-granted sources never affect the current transaction.
- No combinational path from any input to any output.

Test Plan:
- Single requester: after reset, src_req[2]=1 at cycle 0 -> nrn_req=1 and grant_id=2 at cycle 1. Neuron ack rises at cycle 5 -> src_ack[2]=1 and nrn_req=0 at cycle 8. Drop src_req and nrn_ack -> src_ack[2]=0, then rr_ptr=3.
- Round-robin fairness: src_req=4'b1111 held continuously with the neuron model acking after 3 cycles -> grant order 0,1,2,3,0. Each source receives exactly 1 src_ack per 4 grants.
- Leak priority: LEAK_PERIOD=16, src_req[1] held -> every 16 cycles the next grant is grant_id=4 with no src_ack pulse. rr_ptr is unchanged by the leak grant.
- Leak overflow: LEAK_PERIOD=4, neuron ack withheld for 20 cycles -> leak_ovf pulses at each wrap after the first, exactly one leak grant follows the release, and no spurious src_ack occurs.
- Reset mid-handshake: rst=1 in ISSUE with src_req[3]=1 -> next edge src_ack=0, nrn_req=0, grant_vld=0. After rst=0 with src_req[3] still high -> re-granted as channel 3 with rr_ptr=0 search.
- leak_en=0 for 100 cycles with LEAK_PERIOD=8 -> no leak grants and leak_cnt frozen. Re-enabling -> the first leak arrives 8 cycles later minus the frozen count.
